// File: rtl/md_mem_pkg.sv
// Shared types and constants for the per-cell velocity memory write path.
// The VERIFY state exists only when VELOCITY_READBACK_CHECK_EN is defined.
package md_mem_pkg;

  localparam int unsigned VEL_WORD_W          = 96;
  localparam int unsigned FLOAT_W             = 32;
  localparam int unsigned COUNT_ADDR          = 0;
  localparam int unsigned FIRST_PARTICLE_ADDR = 1;

`ifdef VELOCITY_READBACK_CHECK_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STREAM,
    ST_WR_COUNT,
    ST_DONE,
    ST_VERIFY
  } wr_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_WR_COUNT,
    ST_DONE
  } wr_state_e;
`endif

endpackage

// File: rtl/vel_xor_accum.sv
// XOR signature of every word written to the cell RAM, compared against the XOR
// of the words read back READ_LATENCY cycles after each rden (readback check).
module vel_xor_accum
  import md_mem_pkg::*;
#(
  parameter int unsigned W  = VEL_WORD_W,
  parameter int unsigned RL = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear_i,
  input  logic         wr_en_i,
  input  logic [W-1:0] wr_data_i,
  input  logic         rd_en_i,
  input  logic         rd_last_i,
  input  logic [W-1:0] rd_data_i,
  output logic         cmp_done_o,
  output logic         mismatch_o
);

  logic [RL-1:0] vld_q;
  logic [RL-1:0] last_q;
  logic [W-1:0]  wr_acc_q;
  logic [W-1:0]  rd_acc_q;
  logic          cmp_done_q;
  logic          mismatch_q;
  logic          rd_fire;
  logic          rd_fin;

  assign rd_fire    = vld_q[RL-1];
  assign rd_fin     = rd_fire & last_q[RL-1];
  assign cmp_done_o = cmp_done_q;
  assign mismatch_o = mismatch_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q      <= '0;
      last_q     <= '0;
      wr_acc_q   <= '0;
      rd_acc_q   <= '0;
      cmp_done_q <= 1'b0;
      mismatch_q <= 1'b0;
    end else if (clear_i) begin
      vld_q      <= '0;
      last_q     <= '0;
      wr_acc_q   <= '0;
      rd_acc_q   <= '0;
      cmp_done_q <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      // Delay line aligns each rden with the cycle its mem_q is valid.
      vld_q[0]  <= rd_en_i;
      last_q[0] <= rd_en_i & rd_last_i;
      for (int unsigned i = 1; i < RL; i++) begin
        vld_q[i]  <= vld_q[i-1];
        last_q[i] <= last_q[i-1];
      end
      cmp_done_q <= rd_fin;
      if (wr_en_i) begin
        wr_acc_q <= wr_acc_q ^ wr_data_i;
      end
      if (rd_fire) begin
        rd_acc_q <= rd_fin ? '0 : (rd_acc_q ^ rd_data_i);
      end
      if (rd_fin && ((rd_acc_q ^ rd_data_i) != wr_acc_q)) begin
        mismatch_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/velocity_cell_writer.sv
// Writes one cell's particle velocities to RAM addresses 1..N, then N to address 0.
// Optional readback signature check: define VELOCITY_READBACK_CHECK_EN.
module velocity_cell_writer
  import md_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = VEL_WORD_W,
  parameter int unsigned PARTICLE_NUM = 220,
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [DATA_WIDTH-1:0] in_velocity,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_wren,
  output logic                  mem_rden,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic [ADDR_WIDTH-1:0] particle_count,
  output logic                  done,
`ifdef VELOCITY_READBACK_CHECK_EN
  output logic                  check_error,
`endif
  output logic                  overflow
);

  localparam logic [ADDR_WIDTH-1:0] PTR_FULL  = ADDR_WIDTH'(PARTICLE_NUM);
  localparam logic [ADDR_WIDTH-1:0] PTR_FIRST = ADDR_WIDTH'(FIRST_PARTICLE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] PTR_COUNT = ADDR_WIDTH'(COUNT_ADDR);

  wr_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  wren_q, wren_d;
  logic                  rden_q, rden_d;
  logic [ADDR_WIDTH-1:0] count_q, count_d;
  logic                  done_q, done_d;
  logic                  ovf_q, ovf_d;

`ifdef VELOCITY_READBACK_CHECK_EN
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic                  rd_issued_q, rd_issued_d;
  logic                  rd_last_q, rd_last_d;
  logic                  cmp_done;
  logic                  mismatch;

  vel_xor_accum #(
    .W  (DATA_WIDTH),
    .RL (READ_LATENCY)
  ) u_accum (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (start && (state_q == ST_IDLE)),
    .wr_en_i    (wren_q),
    .wr_data_i  (data_q),
    .rd_en_i    (rden_q),
    .rd_last_i  (rd_last_q),
    .rd_data_i  (mem_q),
    .cmp_done_o (cmp_done),
    .mismatch_o (mismatch)
  );

  assign check_error = mismatch;
`else
  localparam int unsigned unused_read_latency = READ_LATENCY;
  logic unused_mem_q;
  assign unused_mem_q = ^mem_q;
`endif

  assign mem_address    = addr_q;
  assign mem_data       = data_q;
  assign mem_wren       = wren_q;
  assign mem_rden       = rden_q;
  assign particle_count = count_q;
  assign done           = done_q;
  assign overflow       = ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= PTR_FIRST;
      addr_q   <= '0;
      data_q   <= '0;
      wren_q   <= 1'b0;
      rden_q   <= 1'b0;
      count_q  <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      wren_q   <= wren_d;
      rden_q   <= rden_d;
      count_q  <= count_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
    end
  end

`ifdef VELOCITY_READBACK_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q    <= '0;
      rd_issued_q <= 1'b0;
      rd_last_q   <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      rd_issued_q <= rd_issued_d;
      rd_last_q   <= rd_last_d;
    end
  end
`endif

  // Memory-port signals are computed here and registered, so every RAM access
  // reaches the port one cycle after the state/handshake that produced it.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    addr_d   = '0;
    data_d   = '0;
    wren_d   = 1'b0;
    rden_d   = 1'b0;
    count_d  = count_q;
    done_d   = 1'b0;
    ovf_d    = ovf_q;
    in_ready = 1'b0;
`ifdef VELOCITY_READBACK_CHECK_EN
    rd_ptr_d    = rd_ptr_q;
    rd_issued_d = rd_issued_q;
    rd_last_d   = 1'b0;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_STREAM;
          wr_ptr_d = PTR_FIRST;
          ovf_d    = 1'b0;
        end
      end

      ST_STREAM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (wr_ptr_q == PTR_FULL) begin
            ovf_d = 1'b1;
          end else begin
            wren_d   = 1'b1;
            addr_d   = wr_ptr_q;
            data_d   = in_velocity;
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
        end
        // in_last without in_valid closes the pass too (zero-particle cell).
        if (in_last) begin
          state_d = ST_WR_COUNT;
        end
      end

      ST_WR_COUNT: begin
        wren_d  = 1'b1;
        addr_d  = PTR_COUNT;
        data_d  = DATA_WIDTH'(wr_ptr_q - 1'b1);
        count_d = wr_ptr_q - 1'b1;
`ifdef VELOCITY_READBACK_CHECK_EN
        rd_ptr_d    = PTR_COUNT;
        rd_issued_d = 1'b0;
        state_d     = ST_VERIFY;
`else
        state_d = ST_DONE;
`endif
      end

`ifdef VELOCITY_READBACK_CHECK_EN
      ST_VERIFY: begin
        if (!rd_issued_q) begin
          rden_d    = 1'b1;
          addr_d    = rd_ptr_q;
          rd_last_d = (rd_ptr_q == count_q);
          rd_ptr_d  = rd_ptr_q + 1'b1;
          if (rd_ptr_q == count_q) begin
            rd_issued_d = 1'b1;
          end
        end
        if (cmp_done) begin
          state_d = ST_DONE;
        end
      end
`endif

      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule
